sync_conditioner: RTL

SYNC_CONDITIONER -- requirements
Module: sync_conditioner

---
 rtl/sync_conditioner_if.sv | 21 ++
 rtl/sync_conditioner.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sync_conditioner_if.sv
// Sync conditioner bus: raw console sync in, conditioned sync and status out.
interface sync_conditioner_if;
    logic hsync_in;
    logic vsync_in;
    logic hsync;
    logic vsync;
    logic hpol;
    logic vpol;
    logic hact;
    logic vact;

    modport master (
        output hsync_in, vsync_in,
        input  hsync, vsync, hpol, vpol, hact, vact
    );

    modport slave (
        input  hsync_in, vsync_in,
        output hsync, vsync, hpol, vpol, hact, vact
    );
endinterface

// File: rtl/sync_conditioner.sv
// Sync conditioner: per-channel synchroniser, glitch filter, polarity and
// activity detection over a fixed window, active-low normalised output.

// One sync channel; WIN is log2 of the measurement window in ticks.
module sync_chan #(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned WIN      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sync_o,
    output logic pol,
    output logic act
);
    localparam logic [3:0]   FLIM = 4'(FILT_LEN - 1);
    localparam logic [WIN:0] HALF = (WIN + 1)'(2 ** (WIN - 1));

    logic [1:0]     meta;      // meta[1] is the synchronised level
    logic           lvl;
    logic           lvl_nxt;
    logic [3:0]     mcnt;
    logic [3:0]     mcnt_nxt;
    logic [WIN-1:0] wcnt;
    logic [WIN:0]   hcnt;
    logic [WIN:0]   hsum;
    logic           seen;
    logic           wend;
    logic           lchg;

    // Two-flop synchroniser for the asynchronous console input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) meta <= 2'b11;
        else     meta <= {meta[0], raw};
    end

    // Accept a new level only after FILT_LEN consecutive disagreeing ticks.
    always_comb begin
        lvl_nxt  = lvl;
        mcnt_nxt = 4'd0;
        if (meta[1] != lvl) begin
            if (mcnt == FLIM) lvl_nxt  = meta[1];
            else              mcnt_nxt = mcnt + 4'd1;
        end
    end

    assign lchg = (lvl_nxt != lvl);
    assign wend = &wcnt;
    // Include the final tick's level so the window covers all 2^WIN ticks.
    assign hsum = hcnt + {{WIN{1'b0}}, lvl};

    // Stable level and mismatch counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl  <= 1'b1;
            mcnt <= 4'd0;
        end else begin
            lvl  <= lvl_nxt;
            mcnt <= mcnt_nxt;
        end
    end

    // Window counter, high-tick count and edge flag; pol/act load at window end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
            hcnt <= '0;
            seen <= 1'b0;
            pol  <= 1'b0;
            act  <= 1'b0;
        end else begin
            wcnt <= wcnt + WIN'(1);
            if (wend) begin
                // A level change on the final tick still belongs to this window.
                pol  <= (hsum < HALF);
                act  <= seen | lchg;
                hcnt <= '0;
                seen <= 1'b0;
            end else begin
                hcnt <= hsum;
                if (lchg) seen <= 1'b1;
            end
        end
    end

    // Output register fed from the next stable level so the output moves on
    // the same edge that L accepts a change; idle high while inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      sync_o <= 1'b1;
        else if (act) sync_o <= lvl_nxt ^ pol;
        else          sync_o <= 1'b1;
    end
endmodule

module sync_conditioner #(
    parameter int unsigned FILT_LEN  = 4,
    parameter int unsigned HWIN_LOG2 = 10,
    parameter int unsigned VWIN_LOG2 = 18
) (
    input logic clk,
    input logic rst,
    sync_conditioner_if.slave bus
);
    // Channel 0 is hsync, channel 1 is vsync.
    logic [1:0] raw;
    logic [1:0] sync_o;
    logic [1:0] pol_o;
    logic [1:0] act_o;

    assign raw = {bus.vsync_in, bus.hsync_in};

    for (genvar c = 0; c < 2; c++) begin : g_chan
        sync_chan #(
            .FILT_LEN (FILT_LEN),
            .WIN      ((c == 0) ? HWIN_LOG2 : VWIN_LOG2)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw[c]),
            .sync_o (sync_o[c]),
            .pol    (pol_o[c]),
            .act    (act_o[c])
        );
    end

    assign bus.hsync = sync_o[0];
    assign bus.vsync = sync_o[1];
    assign bus.hpol  = pol_o[0];
    assign bus.vpol  = pol_o[1];
    assign bus.hact  = act_o[0];
    assign bus.vact  = act_o[1];
endmodule
